// File: rtl/cpu_timing_pkg.sv
// Shared types, default phase constants and helpers for the CPU phase sequencer.
package cpu_timing_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  localparam int NUM_PHASES_DEF  = 8;
  localparam int FETCH_START_DEF = 0;
  localparam int FETCH_END_DEF   = 3;
  localparam int ALU_PHASE_A_DEF = 0;
  localparam int ALU_PHASE_B_DEF = 2;
  localparam int CNT_W_DEF       = 16;

  function automatic int phase_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Bit i set for lo <= i <= hi; callers truncate to their phase count.
  function automatic logic [31:0] window_mask(input int lo, input int hi);
    logic [31:0] m;
    m = 32'd0;
    for (int i = 0; i < 32; i++) begin
      m[i] = (i >= lo) && (i <= hi);
    end
    return m;
  endfunction

endpackage

// File: rtl/cpu_phase_ring.sv
// One-hot phase ring: clear loads phase 0, hold freezes, advance rotates.
module cpu_phase_ring #(
  parameter int N = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         advance_i,
  input  logic         hold_i,
  input  logic         clear_i,
  output logic [N-1:0] ring_o,
  output logic         wrap_o
);

  logic [N-1:0] ring_q, ring_d;

  always_comb begin
    ring_d = ring_q;
    if (clear_i) begin
      ring_d = N'(1);
    end else if (advance_i && !hold_i) begin
      ring_d = {ring_q[N-2:0], ring_q[N-1]};
    end else begin
      ring_d = ring_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ring_q <= N'(1);
    end else begin
      ring_q <= ring_d;
    end
  end

  assign ring_o = ring_q;
  assign wrap_o = advance_i & ~hold_i & ~clear_i & ring_q[N-1];

endmodule

// File: rtl/cpu_phase_seq.sv
// Multi-phase CPU timing generator with stall, single-step and cycle counter.
// Optional stall watchdog enabled by defining CPU_PHASE_SEQ_STALL_LIMIT_EN.
module cpu_phase_seq
  import cpu_timing_pkg::*;
#(
  parameter int NUM_PHASES  = NUM_PHASES_DEF,
  parameter int FETCH_START = FETCH_START_DEF,
  parameter int FETCH_END   = FETCH_END_DEF,
  parameter int ALU_PHASE_A = ALU_PHASE_A_DEF,
  parameter int ALU_PHASE_B = ALU_PHASE_B_DEF,
  parameter int CNT_W       = CNT_W_DEF
`ifdef CPU_PHASE_SEQ_STALL_LIMIT_EN
  ,parameter int STALL_MAX  = 255
`endif
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic                           step_mode,
  input  logic                           step,
  output logic                           fetch,
  output logic                           alu_enable,
  output logic [NUM_PHASES-1:0]          phase_onehot,
  output logic [phase_w(NUM_PHASES)-1:0] phase_idx,
  output logic                           cycle_done,
  output logic [CNT_W-1:0]               cycle_cnt,
  output logic                           running
`ifdef CPU_PHASE_SEQ_STALL_LIMIT_EN
  ,output logic                          stall_timeout
`endif
);

  localparam int PW = phase_w(NUM_PHASES);
  localparam logic [NUM_PHASES-1:0] FETCH_MASK =
    NUM_PHASES'(window_mask(FETCH_START, FETCH_END));
  localparam logic [NUM_PHASES-1:0] ALU_MASK =
    NUM_PHASES'(window_mask(ALU_PHASE_A, ALU_PHASE_A) | window_mask(ALU_PHASE_B, ALU_PHASE_B));

  if (NUM_PHASES < 4 || NUM_PHASES > 16 || FETCH_START < 0 || FETCH_END < FETCH_START ||
      FETCH_END >= NUM_PHASES || ALU_PHASE_A < 0 || ALU_PHASE_A >= NUM_PHASES ||
      ALU_PHASE_B < 0 || ALU_PHASE_B >= NUM_PHASES || CNT_W < 1) begin : g_param_bad
    $fatal(1, "cpu_phase_seq: illegal parameter combination");
  end

  state_e                  mode_q, mode_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_PHASES-1:0]   ring_s;
  logic                    ring_wrap_s, ring_ok_s, run_s;
  logic                    adv_s, clr_s;
  logic [PW-1:0]           idx_s;

  cpu_phase_ring #(.N(NUM_PHASES)) u_ring (
    .clk_i     (clk),
    .rst_i     (reset),
    .advance_i (adv_s),
    .hold_i    (stall),
    .clear_i   (clr_s),
    .ring_o    (ring_s),
    .wrap_o    (ring_wrap_s)
  );

  assign ring_ok_s = $onehot(ring_s);
  assign run_s     = (mode_q == ST_RUN) && ring_ok_s;

  // A corrupted ring or unused mode code falls back to IDLE; the counter survives.
  always_comb begin
    mode_d = mode_q;
    cnt_d  = cnt_q;
    adv_s  = 1'b0;
    clr_s  = 1'b0;
    case (mode_q)
      ST_IDLE: begin
        mode_d = ST_RUN;
        clr_s  = 1'b1;
      end
      ST_RUN: begin
        if (!ring_ok_s) begin
          mode_d = ST_IDLE;
          clr_s  = 1'b1;
        end else if (stall) begin
          mode_d = ST_RUN;
        end else begin
          adv_s = 1'b1;
          if (ring_s[NUM_PHASES-1]) begin
            cnt_d  = cnt_q + CNT_W'(1);
            mode_d = step_mode ? ST_WAIT : ST_RUN;
          end else begin
            mode_d = ST_RUN;
          end
        end
      end
      ST_WAIT: begin
        if (step || !step_mode) begin
          mode_d = ST_RUN;
          clr_s  = 1'b1;
        end else begin
          mode_d = ST_WAIT;
        end
      end
      default: begin
        mode_d = ST_IDLE;
        clr_s  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q <= ST_IDLE;
      cnt_q  <= '0;
    end else begin
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    idx_s = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      idx_s = idx_s | (ring_s[i] ? PW'(i) : PW'(0));
    end
  end

  assign phase_onehot = run_s ? ring_s : '0;
  assign phase_idx    = run_s ? idx_s : '0;
  assign fetch        = run_s & (|(ring_s & FETCH_MASK));
  assign alu_enable   = run_s & ~stall & (|(ring_s & ALU_MASK));
  assign cycle_done   = ring_wrap_s;
  assign cycle_cnt    = cnt_q;
  assign running      = run_s;

`ifdef CPU_PHASE_SEQ_STALL_LIMIT_EN
  localparam int SW = $clog2(STALL_MAX + 1);
  logic [SW-1:0] stall_cnt_q, stall_cnt_d;
  logic          timeout_q, timeout_d;

  // Counts consecutive stalled edges in any state; the flag stays up until reset.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    timeout_d   = timeout_q;
    if (stall) begin
      if (stall_cnt_q != SW'(STALL_MAX)) begin
        stall_cnt_d = stall_cnt_q + SW'(1);
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
      if (stall_cnt_q >= SW'(STALL_MAX - 1)) begin
        timeout_d = 1'b1;
      end else begin
        timeout_d = timeout_q;
      end
    end else begin
      stall_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign stall_timeout = timeout_q;
`endif

endmodule

// File: tb/tb_cpu_phase_seq.sv
// Directed self-checking bench for cpu_phase_seq (default and 5-phase builds).
module tb_cpu_phase_seq;

  logic       clk;
  logic       reset, stall, step_mode, step;
  logic       fetch, alu_enable, cycle_done, running;
  logic [7:0] phase_onehot;
  logic [2:0] phase_idx;
  logic [15:0] cycle_cnt;
`ifdef CPU_PHASE_SEQ_STALL_LIMIT_EN
  logic       stall_timeout;
`endif

  logic       reset5, stall5, step_mode5, step5;
  logic       fetch5, alu5, done5, running5;
  logic [4:0] onehot5;
  logic [2:0] idx5;
  logic [1:0] cnt5;

  int tests_run;
  int tests_failed;

  cpu_phase_seq #(
`ifdef CPU_PHASE_SEQ_STALL_LIMIT_EN
    .STALL_MAX(4)
`endif
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .step_mode    (step_mode),
    .step         (step),
    .fetch        (fetch),
    .alu_enable   (alu_enable),
    .phase_onehot (phase_onehot),
    .phase_idx    (phase_idx),
    .cycle_done   (cycle_done),
    .cycle_cnt    (cycle_cnt),
    .running      (running)
`ifdef CPU_PHASE_SEQ_STALL_LIMIT_EN
    ,.stall_timeout (stall_timeout)
`endif
  );

  cpu_phase_seq #(
    .NUM_PHASES(5), .FETCH_START(1), .FETCH_END(2),
    .ALU_PHASE_A(3), .ALU_PHASE_B(3), .CNT_W(2)
  ) dut5 (
    .clk          (clk),
    .reset        (reset5),
    .stall        (stall5),
    .step_mode    (step_mode5),
    .step         (step5),
    .fetch        (fetch5),
    .alu_enable   (alu5),
    .phase_onehot (onehot5),
    .phase_idx    (idx5),
    .cycle_done   (done5),
    .cycle_cnt    (cnt5),
    .running      (running5)
`ifdef CPU_PHASE_SEQ_STALL_LIMIT_EN
    ,.stall_timeout ()
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int alu_seen;
    int p;
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b1; stall = 1'b0; step_mode = 1'b0; step = 1'b0;
    reset5 = 1'b1; stall5 = 1'b0; step_mode5 = 1'b0; step5 = 1'b0;
    repeat (3) cyc();

    check_val("rst_onehot", 32'(phase_onehot), 32'd0);
    check_val("rst_idx", 32'(phase_idx), 32'd0);
    check_val("rst_outs", 32'({fetch, alu_enable, cycle_done, running}), 32'd0);
    check_val("rst_cnt", 32'(cycle_cnt), 32'd0);

    reset = 1'b0;
    #1;
    check_val("idle_gap", 32'(running), 32'd0);
    cyc();
    check_val("run0_running", 32'(running), 32'd1);
    check_val("run0_onehot", 32'(phase_onehot), 32'h01);

    for (int k = 0; k < 24; k++) begin
      p = k % 8;
      check_val("def_idx", 32'(phase_idx), 32'(p));
      check_val("def_onehot", 32'(phase_onehot), 32'd1 << p);
      check_val("def_fetch", 32'(fetch), (p <= 3) ? 32'd1 : 32'd0);
      check_val("def_alu", 32'(alu_enable), (p == 0 || p == 2) ? 32'd1 : 32'd0);
      check_val("def_done", 32'(cycle_done), (p == 7) ? 32'd1 : 32'd0);
      cyc();
    end
    check_val("def_cnt3", 32'(cycle_cnt), 32'd3);
    check_val("def_idx_back0", 32'(phase_idx), 32'd0);

    // stall five clocks on phase 2
    n = 0;
    alu_seen = 32'(alu_enable);
    cyc(); n++;
    cyc(); n++;
    stall = 1'b1;
    #1;
    check_val("stall_alu_gate", 32'(alu_enable), 32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(); n++;
      if (i < 4) begin
        check_val("stall_hold_idx", 32'(phase_idx), 32'd2);
        check_val("stall_hold_alu", 32'(alu_enable), 32'd0);
        check_val("stall_hold_fetch", 32'(fetch), 32'd1);
      end
    end
    stall = 1'b0;
    #1;
    check_val("stall_rel_idx", 32'(phase_idx), 32'd2);
    alu_seen += 32'(alu_enable);
    for (int g = 0; g < 20; g++) begin
      cyc(); n++;
      if (phase_idx == 3'd0) break;
      alu_seen += 32'(alu_enable);
    end
    check_val("stall_cycle_len", 32'(n), 32'd13);
    check_val("stall_alu_pulses", 32'(alu_seen), 32'd2);
    check_val("stall_cnt", 32'(cycle_cnt), 32'd4);

    // single-step mode
    step_mode = 1'b1;
    repeat (8) cyc();
    check_val("wait_running", 32'(running), 32'd0);
    check_val("wait_onehot", 32'(phase_onehot), 32'd0);
    check_val("wait_cnt", 32'(cycle_cnt), 32'd5);
    stall = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check_val("wait_idle_outs", 32'({fetch, alu_enable, cycle_done, running, phase_idx}), 32'd0);
    end
    stall = 1'b0;
    step = 1'b1;
    #1;
    check_val("step_no_edge", 32'(running), 32'd0);
    cyc();
    step = 1'b0;
    check_val("step_run", 32'(running), 32'd1);
    check_val("step_idx", 32'(phase_idx), 32'd0);
    check_val("step_cnt_hold", 32'(cycle_cnt), 32'd5);
    repeat (8) cyc();
    check_val("step_wait2", 32'(running), 32'd0);
    check_val("step_cnt6", 32'(cycle_cnt), 32'd6);
    step_mode = 1'b0;
    step = 1'b1;
    cyc();
    step = 1'b0;
    check_val("simul_run", 32'(running), 32'd1);
    check_val("simul_idx", 32'(phase_idx), 32'd0);
    repeat (8) cyc();
    check_val("free_run", 32'(running), 32'd1);
    check_val("free_cnt7", 32'(cycle_cnt), 32'd7);

    // asynchronous reset mid-cycle
    repeat (5) cyc();
    check_val("pre_rst_idx", 32'(phase_idx), 32'd5);
    #1;
    reset = 1'b1;
    #1;
    check_val("async_outs", 32'({fetch, alu_enable, cycle_done, running, phase_onehot}), 32'd0);
    check_val("async_cnt", 32'(cycle_cnt), 32'd0);
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    check_val("restart_idle", 32'(running), 32'd0);
    cyc();
    check_val("restart_run", 32'(running), 32'd1);
    check_val("restart_idx", 32'(phase_idx), 32'd0);

`ifdef CPU_PHASE_SEQ_STALL_LIMIT_EN
    stall = 1'b1;
    repeat (3) cyc();
    stall = 1'b0;
    #1;
    check_val("stall3_no_to", 32'(stall_timeout), 32'd0);
    cyc();
    stall = 1'b1;
    repeat (4) cyc();
    stall = 1'b0;
    check_val("stall4_to", 32'(stall_timeout), 32'd1);
    cyc();
    check_val("to_sticky", 32'(stall_timeout), 32'd1);
`endif

    // five-phase build
    reset5 = 1'b0;
    #1;
    check_val("p5_idle", 32'(running5), 32'd0);
    cyc();
    check_val("p5_onehot0", 32'(onehot5), 32'h01);
    for (int k = 0; k < 20; k++) begin
      p = k % 5;
      if (k == 15) check_val("p5_cnt3", 32'(cnt5), 32'd3);
      check_val("p5_idx", 32'(idx5), 32'(p));
      check_val("p5_fetch", 32'(fetch5), (p >= 1 && p <= 2) ? 32'd1 : 32'd0);
      check_val("p5_alu", 32'(alu5), (p == 3) ? 32'd1 : 32'd0);
      check_val("p5_done", 32'(done5), (p == 4) ? 32'd1 : 32'd0);
      check_val("p5_running", 32'(running5), 32'd1);
      cyc();
    end
    check_val("p5_cnt_wrap", 32'(cnt5), 32'd0);
    check_val("p5_idx_back0", 32'(idx5), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
